// File: rtl/subleq_mem_arbiter.sv
// ============================================================================
// Module   : subleq_mem_arbiter
// Purpose  : Round-robin CPU/host arbiter for the shared single-port memory,
//            with capped host lock bursts and a CPU stall counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module subleq_mem_arbiter #(
    parameter int WORD_SIZE      = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int MAX_HOST_BURST = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  areset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0]  cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [WORD_SIZE-1:0]  cpu_rdata,
    input  logic                  host_req,
    input  logic                  host_lock,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [WORD_SIZE-1:0]  host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [WORD_SIZE-1:0]  host_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    output logic [CNT_WIDTH-1:0]  cpu_stall_cnt
);

    localparam int unsigned           BURST_W   = $clog2(MAX_HOST_BURST + 1);
    localparam logic [BURST_W-1:0]    BURST_MAX = BURST_W'(MAX_HOST_BURST);

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_HOST = 2'd2
    } rd_owner_e;

    logic                  last_host_q,   last_host_d;
    logic                  host_locked_q, host_locked_d;
    logic [BURST_W-1:0]    burst_cnt_q,   burst_cnt_d;
    rd_owner_e             rd_pending_q,  rd_pending_d;
    logic [CNT_WIDTH-1:0]  stall_q,       stall_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,    mem_addr_d;
    logic [WORD_SIZE-1:0]  cpu_rdata_q,   host_rdata_q;

    logic                  burst_open;

    assign burst_open = host_locked_q && (burst_cnt_q < BURST_MAX);

    // Grants are forced low while reset is asserted so nothing reaches memory.
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (areset_n) begin
            if (cpu_req && host_req) begin
                if (burst_open || !last_host_q) begin
                    host_gnt = 1'b1;
                end else begin
                    cpu_gnt  = 1'b1;
                end
            end else if (cpu_req) begin
                cpu_gnt  = 1'b1;
            end else if (host_req) begin
                host_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr_d    = mem_addr_q;
        mem_we        = 1'b0;
        mem_wdata     = cpu_wdata;
        rd_pending_d  = RD_NONE;
        last_host_d   = last_host_q;
        host_locked_d = host_locked_q;
        burst_cnt_d   = burst_cnt_q;
        stall_d       = stall_q;

        if (cpu_gnt) begin
            mem_addr_d   = cpu_addr;
            mem_we       = cpu_we;
            rd_pending_d = cpu_we ? RD_NONE : RD_CPU;
            last_host_d  = 1'b0;
        end else if (host_gnt) begin
            mem_addr_d   = host_addr;
            mem_we       = host_we;
            mem_wdata    = host_wdata;
            rd_pending_d = host_we ? RD_NONE : RD_HOST;
            last_host_d  = 1'b1;
        end

        if (host_gnt) begin
            host_locked_d = host_lock;
        end else if (!host_req) begin
            host_locked_d = 1'b0;
        end

        // Burst only counts host grants that actually kept the CPU waiting.
        if (cpu_gnt || !host_locked_d) begin
            burst_cnt_d = '0;
        end else if (host_gnt && cpu_req && (burst_cnt_q < BURST_MAX)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end

        if (cpu_req && !cpu_gnt && (stall_q != {CNT_WIDTH{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    assign mem_addr      = cpu_gnt ? cpu_addr : (host_gnt ? host_addr : mem_addr_q);
    assign cpu_rvalid    = (rd_pending_q == RD_CPU);
    assign host_rvalid   = (rd_pending_q == RD_HOST);
    assign cpu_rdata     = cpu_rvalid  ? mem_rdata : cpu_rdata_q;
    assign host_rdata    = host_rvalid ? mem_rdata : host_rdata_q;
    assign cpu_stall_cnt = stall_q;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            last_host_q   <= 1'b1;
            host_locked_q <= 1'b0;
            burst_cnt_q   <= '0;
            rd_pending_q  <= RD_NONE;
            stall_q       <= '0;
            mem_addr_q    <= '0;
            cpu_rdata_q   <= '0;
            host_rdata_q  <= '0;
        end else begin
            last_host_q   <= last_host_d;
            host_locked_q <= host_locked_d;
            burst_cnt_q   <= burst_cnt_d;
            rd_pending_q  <= rd_pending_d;
            stall_q       <= stall_d;
            mem_addr_q    <= mem_addr_d;
            cpu_rdata_q   <= cpu_rdata;
            host_rdata_q  <= host_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_subleq_mem_arbiter.sv
// ============================================================================
// Module   : tb_subleq_mem_arbiter
// Purpose  : Scoreboard bench for subleq_mem_arbiter with a write-first memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_subleq_mem_arbiter;

    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        host_req = 1'b0, host_lock = 1'b0, host_we = 1'b0;
    logic [15:0] host_addr = '0, host_wdata = '0;
    logic        host_gnt, host_rvalid;
    logic [15:0] host_rdata;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata = '0;
    logic [31:0] cpu_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem    [0:65535];
    logic [15:0] shadow [0:65535];
    logic [15:0] cq[$];
    logic [15:0] hq[$];

    always #5 clk = ~clk;

    subleq_mem_arbiter #(
        .WORD_SIZE(16), .ADDR_WIDTH(16), .MAX_HOST_BURST(4), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .areset_n(areset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_lock(host_lock), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_stall_cnt(cpu_stall_cnt)
    );

    // Write-first synchronous memory
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One bus cycle: drive, check read returns and grant at negedge, advance.
    // exp_g: 0 = no grant, 1 = CPU, 2 = host
    task automatic cyc(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                       input logic hr, input logic hl, input logic hw,
                       input logic [15:0] ha, input logic [15:0] hd, input int exp_g);
        logic [15:0] e;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_lock = hl; host_we = hw; host_addr = ha; host_wdata = hd;
        @(negedge clk);
        chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, cq.size() != 0});
        if (cq.size() != 0) begin
            e = cq.pop_front();
            if (cpu_rvalid) chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, e});
        end
        chk("host_rvalid", {31'd0, host_rvalid}, {31'd0, hq.size() != 0});
        if (hq.size() != 0) begin
            e = hq.pop_front();
            if (host_rvalid) chk("host_rdata", {16'd0, host_rdata}, {16'd0, e});
        end
        chk("cpu_gnt",  {31'd0, cpu_gnt},  {31'd0, exp_g == 1});
        chk("host_gnt", {31'd0, host_gnt}, {31'd0, exp_g == 2});
        if (cpu_gnt) begin
            chk("mem_addr_cpu", {16'd0, mem_addr}, {16'd0, ca});
            chk("mem_we_cpu", {31'd0, mem_we}, {31'd0, cw});
            if (cw) shadow[ca] = cd; else cq.push_back(shadow[ca]);
        end else if (host_gnt) begin
            chk("mem_addr_host", {16'd0, mem_addr}, {16'd0, ha});
            chk("mem_we_host", {31'd0, mem_we}, {31'd0, hw});
            if (hw) shadow[ha] = hd; else hq.push_back(shadow[ha]);
        end else begin
            chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_cpu_gnt",    {31'd0, cpu_gnt},     32'd0);
        chk("rst_host_gnt",   {31'd0, host_gnt},    32'd0);
        chk("rst_cpu_rvalid", {31'd0, cpu_rvalid},  32'd0);
        chk("rst_host_rvalid",{31'd0, host_rvalid}, 32'd0);
        chk("rst_mem_we",     {31'd0, mem_we},      32'd0);
        chk("rst_cpu_rdata",  {16'd0, cpu_rdata},   32'd0);
        chk("rst_host_rdata", {16'd0, host_rdata},  32'd0);
        chk("rst_stall",      cpu_stall_cnt,        32'd0);
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        {cpu_req, cpu_we, host_req, host_lock, host_we} = 5'($urandom);
        cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
        host_addr = 16'($urandom); host_wdata = 16'($urandom);
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        {cpu_req, cpu_we, host_req, host_lock, host_we} = 5'd0;
        @(negedge clk);
        areset_n = 1'b1;
        @(posedge clk);
        #1;
        cq.delete();
        hq.delete();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 16'(i) ^ 16'hA5A5;
            shadow[i] = 16'(i) ^ 16'hA5A5;
        end

        // Reset and idle
        do_reset();
        idle(5);
        chk("idle_stall", cpu_stall_cnt, 32'd0);

        // CPU-only write then read-back
        cyc(1, 1, 16'h0010, 16'h1234, 0, 0, 0, 16'h0, 16'h0, 1);
        cyc(1, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'h0, 16'h0, 1);
        idle(1);
        chk("cpu_only_readback", {16'd0, shadow[16'h0010]}, 32'h1234);
        chk("cpu_only_stall", cpu_stall_cnt, 32'd0);

        // Round-robin from reset
        do_reset();
        for (int i = 0; i < 6; i++)
            cyc(1, 0, 16'h0020 + 16'(i), 16'h0, 1, 0, 0, 16'h0040 + 16'(i), 16'h0, (i % 2 == 0) ? 1 : 2);
        idle(1);
        chk("rr_stall", cpu_stall_cnt, 32'd3);

        // Host lock burst cap: C H H H H C H H H H C H
        do_reset();
        for (int i = 0; i < 12; i++)
            cyc(1, 0, 16'h0100 + 16'(i), 16'h0, 1, 1, 0, 16'h0200 + 16'(i), 16'h0,
                (i == 0 || i == 5 || i == 10) ? 1 : 2);
        chk("burst_stall", cpu_stall_cnt, 32'd9);

        // Lock release: host drops req, CPU wins, then round-robin resumes
        cyc(1, 0, 16'h0300, 16'h0, 0, 1, 0, 16'h0400, 16'h0, 1);
        cyc(1, 0, 16'h0301, 16'h0, 1, 0, 0, 16'h0401, 16'h0, 2);
        cyc(1, 0, 16'h0302, 16'h0, 1, 0, 0, 16'h0402, 16'h0, 1);
        cyc(1, 0, 16'h0303, 16'h0, 1, 0, 0, 16'h0403, 16'h0, 2);
        cyc(1, 1, 16'h0304, 16'hBEEF, 1, 0, 0, 16'h0304, 16'h0, 1);
        cyc(0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0304, 16'h0, 2);
        idle(1);

        // Reset coincident with a granted host read
        host_req = 1'b1; host_lock = 1'b0; host_we = 1'b0; host_addr = 16'h0055;
        @(negedge clk);
        chk("prerst_host_gnt", {31'd0, host_gnt}, 32'd1);
        #1;
        areset_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        host_req = 1'b0;
        chk("rst_pending_rvalid", {31'd0, host_rvalid}, 32'd0);
        @(negedge clk);
        areset_n = 1'b1;
        @(posedge clk);
        #1;
        cq.delete();
        hq.delete();
        idle(3);
        chk("post_rst_stall", cpu_stall_cnt, 32'd0);
        cyc(1, 0, 16'h0060, 16'h0, 1, 0, 0, 16'h0061, 16'h0, 1);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/subleq_mem_arbiter.md
Name: subleq_mem_arbiter

Overview:
- Shares the single-port synchronous program/data memory of the subleq system between two requesters: the CPU and a host/debug port (loader, monitor, memory dump).
- Sits between the CPU bus, the host bus and the memory inside the top-level subleq circuit.
- Arbitrates round-robin, one access per cycle.
- The host may lock the memory for short bursts, capped so the CPU cannot starve.
- Counts the cycles the CPU is stalled, for performance debug.

Parameters:
WORD_SIZE, 16, data word width in bits
ADDR_WIDTH, 16, memory address width in bits
MAX_HOST_BURST, 4, maximum consecutive host grants under lock while the CPU is requesting (must be >= 1)
CNT_WIDTH, 32, width of the CPU stall counter

Ports:
clk  input  1  system clock; all state updates on rising edge
areset_n  input  1  asynchronous active-low reset
cpu_req  input  1  CPU access request; held until granted
cpu_we  input  1  CPU write enable (1 = write, 0 = read)
cpu_addr  input  ADDR_WIDTH  CPU address
cpu_wdata  input  WORD_SIZE  CPU write data
cpu_gnt  output  1  CPU request accepted this cycle
cpu_rvalid  output  1  CPU read data valid
cpu_rdata  output  WORD_SIZE  CPU read data
host_req  input  1  host access request
host_lock  input  1  host requests to keep ownership on the following cycles
host_we  input  1  host write enable
host_addr  input  ADDR_WIDTH  host address
host_wdata  input  WORD_SIZE  host write data
host_gnt  output  1  host request accepted this cycle
host_rvalid  output  1  host read data valid
host_rdata  output  WORD_SIZE  host read data
mem_addr  output  ADDR_WIDTH  memory address
mem_we  output  1  memory write strobe
mem_wdata  output  WORD_SIZE  memory write data
mem_rdata  input  WORD_SIZE  memory read data, valid one cycle after the read address
cpu_stall_cnt  output  CNT_WIDTH  count of cycles with cpu_req=1 and cpu_gnt=0

Behaviour:
- Reset (areset_n=0, asynchronous):
  - last_grant <= HOST, so the CPU wins the first tie.
  - burst_cnt <= 0; rd_pending <= NONE; cpu_stall_cnt <= 0.
  - All gnt, rvalid and mem_we outputs are 0; rdata outputs are 0.
- Grant (combinational from the req inputs and registered state); at most one gnt per cycle:
  - Only one requester asserts req: it is granted.
  - Both assert req, and host_locked=1 with burst_cnt < MAX_HOST_BURST: host granted.
  - Both assert req otherwise: the requester that is not last_grant is granted (round-robin).
- host_locked is a register. It is set on a host grant with host_lock=1. It is cleared on a host grant with host_lock=0, or when host_req=0.
- burst_cnt:
  - Increments on each host grant while the CPU is requesting, saturating at MAX_HOST_BURST.
  - Resets to 0 on any CPU grant or when host_locked clears.
- With both requesting, locked, and burst_cnt = MAX_HOST_BURST: the CPU gets exactly one grant, then the host lock resumes.
- The memory mux drives the granted requester's addr/we/wdata onto mem_* in the same cycle. With no grant: mem_we=0 and mem_addr holds its last value.
- Read latency is 1 cycle:
  - A read granted in cycle N records rd_pending = owner.
  - In cycle N+1 that owner's rvalid=1 and its rdata = mem_rdata, registered through combinationally from the memory output.
  - A pending read never blocks a new grant in cycle N+1 (pipelined back-to-back reads).
- Writes produce no rvalid. A write and a read to the same address in consecutive cycles return the written data, because the memory is write-first at the next access.
- The rdata outputs of the non-owner hold their last value.
- cpu_stall_cnt increments every cycle with cpu_req=1 and cpu_gnt=0, saturating at all-ones.
- last_grant updates only on a grant.
- Reset mid-operation: a pending read is discarded; no rvalid is issued after reset release.

Test Plan:
- Reset and idle:
  - Stimulus: areset_n=0 with random inputs, release, no requests for 5 cycles.
  - Required: all gnt/rvalid/mem_we = 0; cpu_stall_cnt = 0.
- CPU-only traffic:
  - Stimulus: CPU writes 0x1234 to 0x0010, then reads 0x0010.
  - Required: cpu_gnt=1 both cycles; mem_we=1 only in the first; cpu_rvalid=1 with cpu_rdata=0x1234 one cycle after the read grant; cpu_stall_cnt = 0.
- Round-robin:
  - Stimulus: both request reads continuously for 6 cycles, no lock, from reset.
  - Required: grants alternate CPU, HOST, CPU, HOST, CPU, HOST; cpu_stall_cnt = 3; each rvalid pulses on the matching side one cycle later.
- Host lock burst cap (MAX_HOST_BURST=4):
  - Stimulus: host_req=host_lock=1 and cpu_req=1 for 12 cycles.
  - Required: after the initial CPU grant, the sequence is HOST x4, CPU x1, HOST x4, CPU x1.
- Lock release:
  - Stimulus: host locked; host drops host_req for one cycle while the CPU requests.
  - Required: CPU granted that cycle; host_locked cleared; normal round-robin resumes.
- Reset with pending read:
  - Stimulus: assert areset_n=0 in the same cycle a host read is granted.
  - Required: host_rvalid stays 0 on the following cycles; state returns to reset values.
